dsp_ram_scraper: RTL

//  Read-side companion to the Z80 display RAM: dumps all 1024 video bytes, address order
//  0..1023, as a valid/ready byte stream toward the ESP side (remote screen mirror).

---
 rtl/dsp_ram_scraper.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/dsp_ram_scraper.sv
// Streams every byte of the shared display RAM, address 0..WORDS-1, out as a valid/ready
// byte stream. Reads only on cycles the Z80 leaves port A free, covering the 2-cycle read latency.
module dsp_ram_scraper #(
  parameter int ADDR_W = 10,
  parameter int WORDS  = 1024,
  parameter int FIFO_D = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  input  logic              ram_grant,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_ad,
  output logic              ram_oce,
  input  logic [7:0]        ram_dout,
  output logic [7:0]        m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W  = ADDR_W + 1;
  localparam int PTR_W  = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam int FCNT_W = $clog2(FIFO_D + 1);
  localparam int OCC_W  = FCNT_W + 1;
  localparam logic [CNT_W-1:0] END_ADDR  = CNT_W'(WORDS);
  localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(WORDS - 1);
  localparam logic [PTR_W-1:0] PTR_MAX   = PTR_W'(FIFO_D - 1);
  localparam logic [OCC_W-1:0] CREDITS   = OCC_W'(FIFO_D);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  addr_q, addr_d;
  logic [1:0]        pipe_q, pipe_d;
  logic [1:0]        pipe_last_q, pipe_last_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              done_q, done_d;
  logic [7:0]        fifo_data_q [FIFO_D];
  logic              fifo_last_q [FIFO_D];

  logic              active;
  logic              kill;
  logic              push;
  logic              pop;
  logic              head_last;
  logic [OCC_W-1:0]  occupancy;

  // Stream handshake: a byte moves when m_valid & m_ready; m_data/m_last hold while stalled.
  assign active    = (state_q != S_IDLE);
  assign kill      = active & abort;
  assign push      = pipe_q[1];
  assign m_valid   = (fcnt_q != '0);
  assign pop       = m_valid & m_ready;
  assign m_data    = fifo_data_q[rd_ptr_q];
  assign head_last = fifo_last_q[rd_ptr_q];
  assign m_last    = m_valid & head_last;
  assign ram_ad    = addr_q[ADDR_W-1:0];
  assign ram_oce   = pipe_q[0];
  assign busy      = active;
  assign done      = done_q;
  assign dbg_state = state_q;

  // A read is only issued when the FIFO can absorb it plus everything already in flight.
  always_comb begin
    occupancy = OCC_W'(fcnt_q) + OCC_W'(pipe_q[0]) + OCC_W'(pipe_q[1]);
    ram_rd_en = (state_q == S_RUN) && ram_grant && (addr_q < END_ADDR) && (occupancy < CREDITS);
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_RUN;
          addr_d  = '0;
        end
      end
      S_RUN: begin
        if (ram_rd_en) addr_d = addr_q + 1'b1;
        if (addr_q == END_ADDR) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (pop && head_last) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (kill) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
    end
  end

  always_comb begin
    pipe_d      = {pipe_q[0], ram_rd_en};
    pipe_last_d = {pipe_last_q[0], ram_rd_en && (addr_q == LAST_ADDR)};
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fcnt_d      = fcnt_q;
    if (push) wr_ptr_d = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + 1'b1;
    if (push && !pop)      fcnt_d = fcnt_q + 1'b1;
    else if (pop && !push) fcnt_d = fcnt_q - 1'b1;
    if (kill) begin
      pipe_d      = '0;
      pipe_last_d = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      fcnt_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      pipe_q      <= '0;
      pipe_last_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fcnt_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      pipe_q      <= pipe_d;
      pipe_last_q <= pipe_last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fcnt_q      <= fcnt_d;
      done_q      <= done_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push && !kill) begin
      fifo_data_q[wr_ptr_q] <= ram_dout;
      fifo_last_q[wr_ptr_q] <= pipe_last_q[1];
    end
  end

endmodule
